// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases three clock-domain resets in staggered order and watches for lock loss.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 360000,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned REL_GAP_CYC      = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic [2:0] dom_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [1:0] retry_cnt
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // RELEASE counts up to 2*REL_GAP_CYC, so that span also bounds the counter width
  localparam int unsigned MAX_P = max2(max2(max2(RST_PULSE_CYC, LOCK_STABLE_CYC),
                                            max2(LOCK_TIMEOUT_CYC, 2 * REL_GAP_CYC)),
                                       MAX_RETRY);
  localparam int unsigned CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP1     = CW'(REL_GAP_CYC);
  localparam logic [CW-1:0] GAP2     = CW'(2 * REL_GAP_CYC);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL
  } state_t;

  typedef struct packed {
    logic       pll_rst;
    logic [2:0] dom_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;
  } out_t;

  localparam out_t OUT_RST = '{pll_rst: 1'b1, dom_rst: 3'b111, ready: 1'b0,
                               fail: 1'b0, lock_lost: 1'b0, retry_cnt: 2'd0};

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      lock_sync;
  logic            lock_s;
  out_t            out_q, out_d;
  logic [1:0]      retry_n;
  logic            lost;
  logic            rel, run;

  always_ff @(posedge refclk) begin
    if (rst) lock_sync <= '0;
    else     lock_sync <= {lock_sync[0], pll_locked};
  end

  assign lock_s = lock_sync[1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= RESET_PLL;
      cnt   <= '0;
      out_q <= OUT_RST;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      out_q <= out_d;
    end
  end

  always_comb begin
    state_n = state;
    retry_n = out_q.retry_cnt;
    lost    = 1'b0;
    if (restart) begin
      state_n = RESET_PLL;
      retry_n = 2'd0;
    end else begin
      case (state)
        RESET_PLL: if (cnt == RST_LAST) state_n = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) state_n = STABLE;
          else if (cnt == TO_LAST) begin
            if (out_q.retry_cnt >= RETRY_MAX) state_n = FAIL;
            else begin
              retry_n = out_q.retry_cnt + 2'd1;
              state_n = RESET_PLL;
            end
          end
        end
        STABLE: begin
          if (!lock_s)              state_n = WAIT_LOCK;
          else if (cnt == ST_LAST)  state_n = RELEASE;
        end
        RELEASE: begin
          if (!lock_s) begin
            state_n = RESET_PLL;
            retry_n = 2'd0;
          end else if (cnt == GAP2) state_n = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            state_n = RESET_PLL;
            retry_n = 2'd0;
            lost    = 1'b1;
          end
        end
        FAIL:    state_n = FAIL;
        default: state_n = RESET_PLL;
      endcase
    end

    // RUN and FAIL have no timed exit, so their counter simply holds
    if (restart || state_n != state)   cnt_n = '0;
    else if (state inside {RUN, FAIL}) cnt_n = cnt;
    else                               cnt_n = cnt + 1'b1;

    // Outputs are decoded from the next state so the registered copy lines up with it
    rel = (state_n == RELEASE);
    run = (state_n == RUN);
    out_d.pll_rst    = (state_n == RESET_PLL) || (state_n == FAIL);
    out_d.dom_rst[0] = !(rel || run);
    out_d.dom_rst[1] = !(run || (rel && cnt_n >= GAP1));
    out_d.dom_rst[2] = !(run || (rel && cnt_n >= GAP2));
    out_d.ready      = run;
    out_d.fail       = (state_n == FAIL);
    out_d.lock_lost  = lost;
    out_d.retry_cnt  = retry_n;
  end

  assign pll_rst   = out_q.pll_rst;
  assign dom_rst   = out_q.dom_rst;
  assign ready     = out_q.ready;
  assign fail      = out_q.fail;
  assign lock_lost = out_q.lock_lost;
  assign retry_cnt = out_q.retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed-with-random-timing bench for pll_lock_sequencer; expectations come from
// pulse widths, latencies and release spacing derived from the parameters.
module tb_pll_lock_sequencer;
  localparam int RP  = 4;
  localparam int LS  = 8;
  localparam int LT  = 32;
  localparam int MR  = 2;
  localparam int RG  = 2;
  localparam int SYNC_LAT = 2;
  // pll_locked edge -> lock_s (2 flops) -> FSM reacts on the following edge
  localparam int SEE_LAT  = SYNC_LAT + 1;

  logic       refclk = 1'b0;
  logic       rst, pll_locked, restart;
  logic       pll_rst, ready, fail, lock_lost;
  logic [2:0] dom_rst;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;
  int ll_seen = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(LS), .LOCK_TIMEOUT_CYC(LT),
    .MAX_RETRY(MR), .REL_GAP_CYC(RG)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .dom_rst(dom_rst), .ready(ready), .fail(fail),
    .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
    if (lock_lost === 1'b1) ll_seen++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_dom_rst"}, 32'(dom_rst), 32'h7);
    chk({tag, "_ready"},   32'(ready), 32'd0);
    chk({tag, "_fail"},    32'(fail), 32'd0);
    chk({tag, "_lost"},    32'(lock_lost), 32'd0);
    chk({tag, "_retry"},   32'(retry_cnt), 32'd0);
  endtask

  // Cycles pll_rst stays at lvl, counting the current sample
  task automatic meas_pll(input logic lvl, output int n);
    n = 0;
    while (pll_rst === lvl && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (dom_rst === 3'b111 && n < 200) begin
      step();
      n++;
    end
  endtask

  // Called on the first sample where dom_rst has left 111
  task automatic chk_release(input string tag, input int exp_retry);
    int n;
    chk({tag, "_first"}, 32'(dom_rst), 32'h6);
    n = 0;
    while (dom_rst === 3'b110 && n < 100) begin n++; step(); end
    chk({tag, "_gap110"}, 32'(n), 32'(RG));
    n = 0;
    while (dom_rst === 3'b100 && n < 100) begin n++; step(); end
    chk({tag, "_gap100"}, 32'(n), 32'(RG));
    chk({tag, "_dom000"}, 32'(dom_rst), 32'h0);
    chk({tag, "_ready_pre"}, 32'(ready), 32'd0);
    step();
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_dom_run"}, 32'(dom_rst), 32'h0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'(exp_retry));
  endtask

  // Drop lock while in RUN: one lock_lost pulse, then a fresh PLL reset pulse
  task automatic do_loss(input string tag);
    int n, ll0;
    ll0 = ll_seen;
    pll_locked = 1'b0;
    n = 0;
    while (lock_lost !== 1'b1 && n < 20) begin step(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(SEE_LAT));
    chk({tag, "_dom"}, 32'(dom_rst), 32'h7);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    meas_pll(1'b1, n);
    chk({tag, "_pulse"}, 32'(n), 32'(RP));
    chk({tag, "_npulses"}, 32'(ll_seen - ll0), 32'd1);
  endtask

  initial begin
    int n, d, g, ll0;
    rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
    step();
    restart = 1'b1;
    step();
    chk_reset_vals("reset_with_restart");
    restart = 1'b0;
    step();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Normal bring-up: lock 10 cycles after pll_rst falls
    meas_pll(1'b1, n);
    chk("boot_pulse", 32'(n), 32'(RP));
    repeat (10) step();
    pll_locked = 1'b1;
    wait_release(n);
    chk("boot_lat", 32'(n), 32'(SEE_LAT + LS));
    chk_release("boot", 0);

    // Lock loss in RUN, relock after a random delay
    for (int i = 0; i < 3; i++) begin
      do_loss("loss");
      d = int'($urandom_range(0, 20));
      repeat (d) step();
      pll_locked = 1'b1;
      wait_release(n);
      chk("relock_lat", 32'(n), 32'(SEE_LAT + LS));
      chk_release("relock", 0);
    end

    // restart lands on the same edge the FSM first sees lock low
    ll0 = ll_seen;
    pll_locked = 1'b0;
    repeat (SEE_LAT - 1) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("coinc_lost", 32'(lock_lost), 32'd0);
    chk("coinc_pll_rst", 32'(pll_rst), 32'd1);
    chk("coinc_dom", 32'(dom_rst), 32'h7);
    chk("coinc_ready", 32'(ready), 32'd0);
    meas_pll(1'b1, n);
    chk("coinc_pulse", 32'(n), 32'(RP));
    chk("coinc_npulses", 32'(ll_seen - ll0), 32'd0);

    // Never locked: MR+1 attempts each with a full timeout, then FAIL
    for (int a = 0; a <= MR; a++) begin
      meas_pll(1'b0, n);
      chk("nolock_wait", 32'(n), 32'(LT));
      if (a < MR) begin
        chk("nolock_retry", 32'(retry_cnt), 32'(a + 1));
        chk("nolock_fail_lo", 32'(fail), 32'd0);
        meas_pll(1'b1, n);
        chk("nolock_pulse", 32'(n), 32'(RP));
      end
    end
    chk("fail_flag", 32'(fail), 32'd1);
    chk("fail_retry", 32'(retry_cnt), 32'(MR));
    chk("fail_pll_rst", 32'(pll_rst), 32'd1);
    chk("fail_dom", 32'(dom_rst), 32'h7);
    pll_locked = 1'b1;
    d = int'($urandom_range(5, 20));
    repeat (d) step();
    chk("fail_hold", 32'(fail), 32'd1);
    chk("fail_hold_pll_rst", 32'(pll_rst), 32'd1);
    chk("fail_hold_retry", 32'(retry_cnt), 32'(MR));
    pll_locked = 1'b0;
    repeat (4) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_fail", 32'(fail), 32'd0);
    chk("restart_retry", 32'(retry_cnt), 32'd0);
    chk("restart_dom", 32'(dom_rst), 32'h7);
    meas_pll(1'b1, n);
    chk("restart_pulse", 32'(n), 32'(RP));

    // One timeout to consume a retry, then a lock glitch during STABLE
    meas_pll(1'b0, n);
    chk("pre_glitch_wait", 32'(n), 32'(LT));
    chk("pre_glitch_retry", 32'(retry_cnt), 32'd1);
    meas_pll(1'b1, n);
    chk("pre_glitch_pulse", 32'(n), 32'(RP));
    d = int'($urandom_range(0, 5));
    repeat (d) step();
    pll_locked = 1'b1;
    g = int'($urandom_range(1, LS));
    repeat (g) step();
    pll_locked = 1'b0;
    step();
    chk("glitch_no_release", 32'(dom_rst), 32'h7);
    pll_locked = 1'b1;
    wait_release(n);
    chk("glitch_lat", 32'(n), 32'(SEE_LAT + LS));
    chk_release("glitch", 1);

    // rst (with a coincident restart) in the middle of RELEASE
    do_loss("loss2");
    d = int'($urandom_range(0, 20));
    repeat (d) step();
    pll_locked = 1'b1;
    n = 0;
    while (dom_rst !== 3'b100 && n < 200) begin step(); n++; end
    chk("mid_release_reached", 32'(dom_rst), 32'h4);
    rst = 1'b1;
    restart = 1'b1;
    step();
    rst = 1'b0;
    restart = 1'b0;
    chk_reset_vals("mid_release_rst");
    meas_pll(1'b1, n);
    chk("post_rst_pulse", 32'(n), 32'(RP));
    wait_release(n);
    chk("post_rst_lat", 32'(n), 32'(1 + LS));
    chk_release("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
